// File: rtl/grid_pr_slot_join.sv
// grid_pr_slot_join
// Input-staging and join stage for one reconfigurable-grid slot. Each of the
// NUM_INPUTS operand channels is one of the following:
// - a stream channel: a first-word-fall-through FIFO;
// - a constant channel: a single reloadable register;
// - disabled.
// The stage presents the joined operand set to the slot's operation unit (OU)
// with a valid/ack handshake.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   data_in        channel i operand at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_valid_in  per-channel push request
//   data_ready_in  per-channel space available (registered state only)
//   input_mask     1 = channel participates in the join (quasi-static)
//   const_mode     1 = channel is a constant operand (quasi-static)
//   flush          synchronous clear of all channel state
//   ou_data        joined operand set; lanes that are not valid read 0
//   ou_valid       joined set available
//   ou_ack         OU consumes the joined set
//   fifo_level     per-channel occupancy, CW bits each
//   overflow_err   sticky: a push was dropped on a full enabled stream channel
module grid_pr_slot_join #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]            data_valid_in,
  output logic [NUM_INPUTS-1:0]            data_ready_in,
  input  logic [NUM_INPUTS-1:0]            input_mask,
  input  logic [NUM_INPUTS-1:0]            const_mode,
  input  logic                             flush,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] ou_data,
  output logic                             ou_valid,
  input  logic                             ou_ack,
  output logic [NUM_INPUTS*CW-1:0]         fifo_level,
  output logic                             overflow_err
);

  localparam int PW = $clog2(DEPTH);

  logic [NUM_INPUTS-1:0] w_stream;   // enabled stream channel
  logic [NUM_INPUTS-1:0] w_lane_ok;  // channel does not block the join
  logic [NUM_INPUTS-1:0] w_drop;     // push lost on a full stream channel
  logic                  w_pop;
  logic                  r_overflow;

  // Flush outranks the ack, so a flushed set is never also consumed.
  assign w_pop        = ou_valid & ou_ack & ~flush;
  assign ou_valid     = (|input_mask) & (&w_lane_ok);
  assign overflow_err = r_overflow;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : gen_ch
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]         r_wr_ptr;
      logic [PW-1:0]         r_rd_ptr;
      logic [CW-1:0]         r_level;
      logic [DATA_WIDTH-1:0] r_const;
      logic                  r_const_loaded;
      logic [DATA_WIDTH-1:0] w_din;
      logic                  w_ready;
      logic                  w_push;
      logic                  w_do_pop;
      logic                  w_const_push;

      assign w_din        = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_stream[gi] = input_mask[gi] & ~const_mode[gi];
      // Only stream channels can ever be full; others always accept.
      assign w_ready      = w_stream[gi] ? (r_level < CW'(DEPTH)) : 1'b1;
      assign w_push       = w_stream[gi] & data_valid_in[gi] & w_ready & ~flush;
      assign w_do_pop     = w_stream[gi] & w_pop;
      assign w_const_push = input_mask[gi] & const_mode[gi] & data_valid_in[gi] & ~flush;
      assign w_drop[gi]   = w_stream[gi] & data_valid_in[gi] & ~w_ready;

      assign data_ready_in[gi] = w_ready;
      assign fifo_level[gi*CW +: CW] = const_mode[gi] ? '0 : r_level;

      assign w_lane_ok[gi] = ~input_mask[gi] |
                             (const_mode[gi] ? r_const_loaded : (r_level != '0));

      // Fall-through head read; lanes without valid content read 0.
      assign ou_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        !input_mask[gi] ? '0 :
        const_mode[gi]  ? (r_const_loaded ? r_const : '0) :
                          ((r_level != '0) ? r_mem[r_rd_ptr] : '0);

      // Storage holds no control state, so it needs no reset.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_din;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wr_ptr       <= '0;
          r_rd_ptr       <= '0;
          r_level        <= '0;
          r_const        <= '0;
          r_const_loaded <= 1'b0;
        end else if (flush) begin
          r_wr_ptr       <= '0;
          r_rd_ptr       <= '0;
          r_level        <= '0;
          r_const_loaded <= 1'b0;
        end else begin
          // DEPTH is a power of two, so the pointers wrap naturally.
          if (w_push)   r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
          case ({w_push, w_do_pop})
            2'b10:   r_level <= r_level + CW'(1);
            2'b01:   r_level <= r_level - CW'(1);
            default: r_level <= r_level;
          endcase
          if (w_const_push) begin
            r_const        <= w_din;
            r_const_loaded <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grid_pr_slot_join.sv
// Bench for grid_pr_slot_join (NUM_INPUTS=2, DATA_WIDTH=32, DEPTH=4).
// Expected sets are queued by the stimulus; a monitor compares every
// consumed set (ou_valid && ou_ack) against the queue head.
module tb_grid_pr_slot_join;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   data_in;
  logic [N-1:0]      data_valid_in;
  logic [N-1:0]      data_ready_in;
  logic [N-1:0]      input_mask;
  logic [N-1:0]      const_mode;
  logic              flush;
  logic [N*DW-1:0]   ou_data;
  logic              ou_valid;
  logic              ou_ack;
  logic [N*CW-1:0]   fifo_level;
  logic              overflow_err;

  grid_pr_slot_join #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
    .data_ready_in(data_ready_in), .input_mask(input_mask),
    .const_mode(const_mode), .flush(flush), .ou_data(ou_data),
    .ou_valid(ou_valid), .ou_ack(ou_ack), .fifo_level(fifo_level),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N*DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    data_valid_in = v;
    data_in       = {d1, d0};
  endtask

  function automatic logic [N*DW-1:0] set2(input logic [31:0] d1, input logic [31:0] d0);
    return {d1, d0};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && ou_valid && ou_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL set: unexpected set %0h expected none", ou_data);
      end else begin
        logic [N*DW-1:0] e;
        e = exp_q.pop_front();
        $display("set consumed: got %0h expected %0h", ou_data, e);
        check("set", ou_data, e);
      end
    end
  end

  // Mask and mode must stay stable while a set is on offer.
  logic         prev_v = 1'b0;
  logic [N-1:0] prev_m = '0;
  logic [N-1:0] prev_c = '0;
  always @(negedge clk) begin
    if (!rst && prev_v && ou_valid && (input_mask !== prev_m || const_mode !== prev_c)) begin
      n_checks++;
      n_fail++;
      $display("FAIL mask_stable: got %0h/%0h expected %0h/%0h",
               input_mask, const_mode, prev_m, prev_c);
    end
    prev_v = ou_valid & ~rst;
    prev_m = input_mask;
    prev_c = const_mode;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; data_in = '0; data_valid_in = '0; input_mask = 2'b11;
    const_mode = 2'b00; flush = 1'b0; ou_ack = 1'b0;
    #2;
    check("rst_valid", ou_valid, 0);
    check("rst_data", ou_data, 0);
    check("rst_ready", data_ready_in, 2'b11);
    check("rst_level", fifo_level, 0);
    check("rst_err", overflow_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two-channel join at different rates.
    drive(2'b01, 32'h11, 0); tick();
    check("t1_wait_valid", ou_valid, 0);
    check("t1_lvl0_1", fifo_level[CW-1:0], 1);
    drive(2'b01, 32'h22, 0); tick();
    drive(2'b00, 0, 0); tick(); tick();
    check("t1_lvl0_2", fifo_level[CW-1:0], 2);
    check("t1_still_wait", ou_valid, 0);
    drive(2'b10, 0, 32'hA0); exp_q.push_back(set2(32'hA0, 32'h11)); tick();
    check("t1_latency", ou_valid, 1);
    drive(2'b00, 0, 0); ou_ack = 1'b1; tick(); ou_ack = 1'b0;
    check("t1_drop_valid", ou_valid, 0);
    check("t1_lvl0_after", fifo_level[CW-1:0], 1);
    ou_ack = 1'b1; tick(); ou_ack = 1'b0;
    check("t1_ack_ignored", fifo_level[CW-1:0], 1);
    drive(2'b10, 0, 32'hB0); exp_q.push_back(set2(32'hB0, 32'h22)); tick();
    drive(2'b00, 0, 0); ou_ack = 1'b1; tick(); ou_ack = 1'b0;
    check("t1_empty", fifo_level, 0);

    // Full / overflow on ch0.
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 32'h100 + i, 0); tick();
      if (i == 3) begin
        check("t2_not_ready", data_ready_in[0], 0);
        check("t2_err_before", overflow_err, 0);
      end
    end
    drive(2'b00, 0, 0);
    check("t2_err", overflow_err, 1);
    check("t2_level", fifo_level[CW-1:0], 4);
    check("t2_head", ou_data[DW-1:0], 32'h100);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t2_flush_lvl", fifo_level, 0);
    check("t2_flush_err", overflow_err, 0);
    check("t2_flush_rdy", data_ready_in, 2'b11);

    // Simultaneous push/pop with wrap; ch1 disabled and pushing junk.
    input_mask = 2'b01;
    flush = 1'b1; drive(2'b01, 32'hDEAD, 0); tick(); flush = 1'b0;
    check("t3_flush_push_dropped", fifo_level[CW-1:0], 0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'h200 + i, 32'hBAD0 + i); tick();
    end
    drive(2'b00, 0, 0);
    check("t3_full", fifo_level[CW-1:0], 4);
    check("t3_ready", data_ready_in, 2'b10);
    check("t3_no_err", overflow_err, 0);
    ou_ack = 1'b1; exp_q.push_back(set2(0, 32'h200)); tick();
    check("t3_lvl3", fifo_level[CW-1:0], 3);
    for (int i = 4; i < 8; i++) begin
      drive(2'b01, 32'h200 + i, 0); exp_q.push_back(set2(0, 32'h200 + i - 3)); tick();
      check("t3_lvl_hold", fifo_level[CW-1:0], 3);
    end
    drive(2'b00, 0, 0);
    for (int k = 5; k < 8; k++) begin
      exp_q.push_back(set2(0, 32'h200 + k)); tick();
    end
    ou_ack = 1'b0;
    check("t3_drained", fifo_level[CW-1:0], 0);
    check("t3_valid_low", ou_valid, 0);

    // Constant mode on ch1.
    flush = 1'b1; tick(); flush = 1'b0;
    input_mask = 2'b11; const_mode = 2'b10;
    drive(2'b10, 0, 32'h7); tick();
    check("t4_const_lvl", fifo_level[2*CW-1:CW], 0);
    check("t4_wait", ou_valid, 0);
    drive(2'b01, 32'h301, 0); exp_q.push_back(set2(32'h7, 32'h301)); tick();
    check("t4_valid", ou_valid, 1);
    ou_ack = 1'b1;
    drive(2'b01, 32'h302, 0); exp_q.push_back(set2(32'h7, 32'h302)); tick();
    check("t4_lvl_pushpop1", fifo_level[CW-1:0], 1);
    drive(2'b01, 32'h303, 0); exp_q.push_back(set2(32'h7, 32'h303)); tick();
    drive(2'b00, 0, 0); tick(); ou_ack = 1'b0;
    check("t4_ch0_empty", fifo_level[CW-1:0], 0);
    check("t4_ch1_lvl", fifo_level[2*CW-1:CW], 0);
    drive(2'b11, 32'h304, 32'h9); exp_q.push_back(set2(32'h9, 32'h304)); tick();
    drive(2'b00, 0, 0); ou_ack = 1'b1; tick(); ou_ack = 1'b0;
    check("t4_done", ou_valid, 0);

    // All-zero mask.
    flush = 1'b1; tick(); flush = 1'b0;
    input_mask = 2'b00; const_mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 32'h600 + i, 32'h700 + i); tick();
      check("t5_no_valid", ou_valid, 0);
    end
    drive(2'b00, 0, 0);
    check("t5_ready", data_ready_in, 2'b11);
    check("t5_err", overflow_err, 0);

    // Asynchronous reset with both FIFOs at level 2.
    flush = 1'b1; tick(); flush = 1'b0;
    input_mask = 2'b11;
    drive(2'b11, 32'h401, 32'h501); tick();
    drive(2'b11, 32'h402, 32'h502); tick();
    drive(2'b00, 0, 0);
    check("t6_levels", fifo_level, {3'd2, 3'd2});
    check("t6_valid", ou_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", ou_valid, 0);
    check("t6_rst_data", ou_data, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_ready", data_ready_in, 2'b11);
    @(posedge clk); #3 rst = 1'b0;
    tick();
    drive(2'b11, 32'h55, 32'h66); exp_q.push_back(set2(32'h66, 32'h55)); tick();
    drive(2'b00, 0, 0); ou_ack = 1'b1; tick(); ou_ack = 1'b0;
    check("t6_after", ou_valid, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
